alu_arbiter: RTL and testbench

Shares one alu instance between NUM_REQ independent requesters using round-robin arbitration.
- Accepts one operation at a time through a valid/ready handshake.
- Drives the ALU load/control/operand inputs and captures the ALU result.
- Returns the result tagged with the requester ID.
- Sits between the CPU's execute-stage clients and the single shared ALU.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_arbiter_if.sv | 38 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/alu_arbiter.sv | 121 ++++++++++++
 tb/tb_alu_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, default datapath width and arbiter FSM encoding.
package alu_pkg;

  localparam int DATA_W_DEF = 16;

  localparam logic [2:0] ALU_OP_ADD = 3'b001;
  localparam logic [2:0] ALU_OP_SUB = 3'b010;
  localparam logic [2:0] ALU_OP_MUL = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == ALU_OP_ADD) || (op == ALU_OP_SUB) || (op == ALU_OP_MUL);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, ALU-side and response signals of the shared-ALU arbiter.
interface alu_arbiter_if import alu_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [3*NUM_REQ-1:0]      req_control;
  logic [DATA_W*NUM_REQ-1:0] req_a;
  logic [DATA_W*NUM_REQ-1:0] req_b;

  logic                      alu_load;
  logic [2:0]                alu_control;
  logic [DATA_W-1:0]         alu_din_a;
  logic [DATA_W-1:0]         alu_din_b;
  logic                      alu_valid_dout;
  logic [DATA_W-1:0]         alu_dout;

  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;

  // master = requesters, ALU and response consumer; slave = the arbiter
  modport master (
    output req_valid, req_control, req_a, req_b, alu_valid_dout, alu_dout,
    input  req_ready, alu_load, alu_control, alu_din_a, alu_din_b,
           rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_control, req_a, req_b, alu_valid_dout, alu_dout,
    output req_ready, alu_load, alu_control, alu_din_a, alu_din_b,
           rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts at i_ptr+1 and wraps to 0.
// Zero latency; no backpressure of its own, o_gnt is all-zero when nothing requests.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx
);

  logic w_found;
  int   w_cand;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = (int'(i_ptr) + k) % NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && (j == w_cand) && i_req[j]) begin
          o_gnt[j] = 1'b1;
          o_idx    = ID_W'(j);
          w_found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU: accept, issue next cycle, respond 3 cycles after accept; 4-cycle throughput.
// req_ready only in IDLE, no response backpressure. ALU_ARB_OPCHECK_EN answers illegal opcodes with rsp_err.
module alu_arbiter import alu_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ID_W    = 2
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  arb_state_t          r_state, w_next_state;
  logic [ID_W-1:0]     r_ptr, r_id, r_rsp_id, w_idx;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [2:0]          r_op, w_sel_op;
  logic [DATA_W-1:0]   r_a, r_b, r_rsp_data, w_sel_a, w_sel_b;
  logic                w_accept, w_bad_op;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  always_comb begin
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_gnt[j]) begin
        w_sel_op = bus.req_control[3*j +: 3];
        w_sel_a  = bus.req_a[DATA_W*j +: DATA_W];
        w_sel_b  = bus.req_b[DATA_W*j +: DATA_W];
      end
    end
  end

  assign w_accept = (r_state == ST_IDLE) && (|w_gnt);

`ifdef ALU_ARB_OPCHECK_EN
  assign w_bad_op = !op_is_legal(w_sel_op);
`else
  assign w_bad_op = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next_state = w_bad_op ? ST_RESP : ST_ISSUE;
      ST_ISSUE: w_next_state = ST_WAIT;
      ST_WAIT:  if (bus.alu_valid_dout) w_next_state = ST_RESP;
      ST_RESP:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // ptr starts at the last requester so requester 0 wins first out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr      <= ID_W'(NUM_REQ - 1);
      r_id       <= '0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_rsp_id   <= '0;
      r_rsp_data <= '0;
    end else begin
      if (w_accept) begin
        r_ptr <= w_idx;
        r_id  <= w_idx;
        r_op  <= w_sel_op;
        r_a   <= w_sel_a;
        r_b   <= w_sel_b;
        if (w_bad_op) begin
          r_rsp_id   <= w_idx;
          r_rsp_data <= '0;
        end
      end
      if ((r_state == ST_WAIT) && bus.alu_valid_dout) begin
        r_rsp_id   <= r_id;
        r_rsp_data <= bus.alu_dout;
      end
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_accept && w_bad_op) begin
      r_err <= 1'b1;
    end else if ((r_state == ST_WAIT) && bus.alu_valid_dout) begin
      r_err <= 1'b0;
    end
  end

  assign bus.rsp_err = r_err;
`else
  assign bus.rsp_err = 1'b0;
`endif

  // ready is forced low while reset is held so every output reads 0 in reset
  assign bus.req_ready   = ((r_state == ST_IDLE) && reset) ? w_gnt : '0;
  assign bus.alu_load    = (r_state == ST_ISSUE);
  assign bus.alu_control = r_op;
  assign bus.alu_din_a   = r_a;
  assign bus.alu_din_b   = r_b;
  assign bus.rsp_valid   = (r_state == ST_RESP);
  assign bus.rsp_id      = r_rsp_id;
  assign bus.rsp_data    = r_rsp_data;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural registered ALU.
module tb_alu_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int IW = 2;
`ifdef ALU_ARB_OPCHECK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  typedef struct {
    int          id;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] data;
    logic        err;
    logic        issue;
    int          lat;
    int          cyc;
  } sb_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0] t_vld = '0;
  logic [2:0]    t_op[NR];
  logic [15:0]   t_a[NR];
  logic [15:0]   t_b[NR];
  logic [15:0]   t_exp[NR];
  logic          m_vld = 1'b0;
  logic [15:0]   m_dout = '0;
  logic          inj_vld = 1'b0;

  int  n_checks = 0, n_fail = 0;
  int  cyc = 0, acc_cnt = 0, load_cnt = 0, load_exp = 0, rsp_raw = 0;
  bit  prev_acc = 1'b0;
  sb_t sb[$];
  int  acc_q[$];

  alu_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) bus();

  alu_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.req_valid      = t_vld;
  assign bus.req_control    = {t_op[3], t_op[2], t_op[1], t_op[0]};
  assign bus.req_a          = {t_a[3], t_a[2], t_a[1], t_a[0]};
  assign bus.req_b          = {t_b[3], t_b[2], t_b[1], t_b[0]};
  assign bus.alu_valid_dout = m_vld | inj_vld;
  assign bus.alu_dout       = m_dout;

  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    case (op)
      3'b001:  r = a + b;
      3'b010:  r = b - a;
      3'b011:  r = a * b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Registered ALU: result and valid one cycle after load
  always @(posedge clk) begin
    m_vld <= bus.alu_load;
    if (bus.alu_load) m_dout <= alu_fn(bus.alu_control, bus.alu_din_a, bus.alu_din_b);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_bad(input logic [2:0] op);
    return OPCHK && !(op inside {3'b001, 3'b010, 3'b011});
  endfunction

  function automatic int first_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic sb_t mk_entry(input int i);
    sb_t e;
    e.id    = i;
    e.op    = t_op[i];
    e.a     = t_a[i];
    e.b     = t_b[i];
    e.data  = t_exp[i];
    e.err   = is_bad(t_op[i]);
    e.issue = !is_bad(t_op[i]);
    e.lat   = is_bad(t_op[i]) ? 1 : 3;
    e.cyc   = cyc;
    return e;
  endfunction

  // Monitor: accepts push the scoreboard, issues and responses are checked against its head
  always @(negedge clk) begin
    if (!reset) begin
      prev_acc <= 1'b0;
    end else begin
      if (prev_acc) check("rdy_one_cycle", 32'(bus.req_ready), 32'(0));
      if (bus.alu_load) begin
        load_cnt <= load_cnt + 1;
        if (sb.size() == 0) check("load_orphan", 32'(sb.size()), 32'(1));
        else begin
          check("load_expected", 32'(bus.alu_load), 32'(sb[0].issue));
          check("load_op", 32'(bus.alu_control), 32'(sb[0].op));
          check("load_a", 32'(bus.alu_din_a), 32'(sb[0].a));
          check("load_b", 32'(bus.alu_din_b), 32'(sb[0].b));
          check("load_lat", 32'(cyc - sb[0].cyc), 32'(1));
        end
      end
      if (bus.rsp_valid) begin
        if (sb.size() == 0) check("rsp_orphan", 32'(sb.size()), 32'(1));
        else begin
          check("rsp_id", 32'(bus.rsp_id), 32'(sb[0].id));
          check("rsp_data", 32'(bus.rsp_data), 32'(sb[0].data));
          check("rsp_err", 32'(bus.rsp_err), 32'(sb[0].err));
          check("rsp_lat", 32'(cyc - sb[0].cyc), 32'(sb[0].lat));
          sb.delete(0);
        end
      end
      if ((bus.req_ready & t_vld) != '0) begin
        check("rdy_onehot", 32'($countones(bus.req_ready)), 32'(1));
        sb.push_back(mk_entry(first_idx(bus.req_ready & t_vld)));
        acc_q.push_back(first_idx(bus.req_ready & t_vld));
        acc_cnt <= acc_cnt + 1;
        if (!is_bad(t_op[first_idx(bus.req_ready & t_vld)])) load_exp <= load_exp + 1;
        prev_acc <= 1'b1;
      end else begin
        prev_acc <= 1'b0;
      end
    end
  end

  always @(negedge clk) if (bus.rsp_valid) rsp_raw <= rsp_raw + 1;

  task automatic wait_acc(input int target, input int budget);
    for (int k = 0; k < budget && acc_cnt < target; k++) begin
      @(negedge clk); #1;
    end
    check("accept_reached", 32'(acc_cnt >= target), 32'(1));
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && sb.size() != 0; k++) begin
      @(negedge clk); #1;
    end
    check("drain", 32'(sb.size()), 32'(0));
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] e);
    t_op[i] = op; t_a[i] = a; t_b[i] = b; t_exp[i] = e;
  endtask

  task automatic set_table();
    set_req(0, 3'b001, 16'd1, 16'd2, 16'd3);
    set_req(1, 3'b001, 16'd10, 16'd20, 16'd30);
    set_req(2, 3'b010, 16'd3, 16'd10, 16'd7);
    set_req(3, 3'b011, 16'd4, 16'd5, 16'd20);
  endtask

  task automatic send(input int i, input logic [2:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] e);
    int tgt;
    @(posedge clk); #1;
    set_req(i, op, a, b, e);
    t_vld[i] = 1'b1;
    tgt = acc_cnt + 1;
    wait_acc(tgt, 40);
    @(posedge clk); #1;
    t_vld[i] = 1'b0;
    wait_done(40);
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_req_ready"}, 32'(bus.req_ready), 32'(0));
    check({pfx, "_alu_load"}, 32'(bus.alu_load), 32'(0));
    check({pfx, "_alu_control"}, 32'(bus.alu_control), 32'(0));
    check({pfx, "_alu_din_a"}, 32'(bus.alu_din_a), 32'(0));
    check({pfx, "_alu_din_b"}, 32'(bus.alu_din_b), 32'(0));
    check({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(0));
    check({pfx, "_rsp_id"}, 32'(bus.rsp_id), 32'(0));
    check({pfx, "_rsp_data"}, 32'(bus.rsp_data), 32'(0));
    check({pfx, "_rsp_err"}, 32'(bus.rsp_err), 32'(0));
  endtask

  initial begin
    int base, tgt, ac, rr, j;
    int fair_ord[6] = '{0, 1, 2, 3, 0, 1};

    // Reset state, with every requester asserting valid
    set_table();
    t_vld = '1;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    t_vld = '0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Fairness: all requesters hold valid for six accepts
    base = acc_q.size();
    @(posedge clk); #1;
    set_table();
    t_vld = '1;
    tgt = acc_cnt + 6;
    wait_acc(tgt, 60);
    @(posedge clk); #1;
    t_vld = '0;
    wait_done(40);
    for (int k = 0; k < 6; k++) begin
      if (acc_q.size() > base + k) check("fair_order", 32'(acc_q[base + k]), 32'(fair_ord[k]));
      else check("fair_missing", 32'(acc_q.size()), 32'(base + k + 1));
    end

    // Single add, then wrap-around cases and an illegal opcode
    send(0, 3'b001, 16'd5, 16'd7, 16'd12);
    send(3, 3'b011, 16'h0100, 16'h0100, 16'h0000);
    send(1, 3'b010, 16'h0001, 16'h0000, 16'hFFFF);
    send(2, 3'b001, 16'hFFFF, 16'h0002, 16'h0001);
    send(1, 3'b111, 16'h1234, 16'h5678, 16'h0000);

    // Reset while the operation is in flight
    @(posedge clk); #1;
    set_req(1, 3'b001, 16'd1, 16'd1, 16'd2);
    t_vld[1] = 1'b1;
    base = load_cnt;
    for (int k = 0; k < 20 && load_cnt == base; k++) begin
      @(negedge clk); #1;
    end
    check("rst_issue_seen", 32'(load_cnt > base), 32'(1));
    t_vld[1] = 1'b0;
    reset = 1'b0;
    sb.delete();
    rr = rsp_raw;
    #1;
    check_outputs_zero("midrst");
    repeat (3) @(negedge clk);
    check("midrst_no_rsp", 32'(rsp_raw), 32'(rr));
    @(posedge clk); #1;
    reset = 1'b1;
    set_req(0, 3'b001, 16'd2, 16'd3, 16'd5);
    set_req(3, 3'b010, 16'd1, 16'd9, 16'd8);
    t_vld = 4'b1001;
    tgt = acc_cnt + 1;
    wait_acc(tgt, 20);
    check("rst_first_grant", 32'(acc_q[$]), 32'(0));
    @(posedge clk); #1;
    t_vld[0] = 1'b0;
    wait_acc(tgt + 1, 40);
    check("rst_second_grant", 32'(acc_q[$]), 32'(3));
    @(posedge clk); #1;
    t_vld[3] = 1'b0;
    wait_done(40);

    // Idle gaps: short valid glitches and a stray ALU valid must do nothing
    send(2, 3'b001, 16'd100, 16'd23, 16'd123);
    ac = acc_cnt;
    rr = rsp_raw;
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      j = $urandom_range(0, NR - 1);
      t_vld[j] = 1'b1;
      #2;
      t_vld[j] = 1'b0;
      if (it == 2) begin
        @(posedge clk); #1;
        inj_vld = 1'b1;
        @(posedge clk); #1;
        inj_vld = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    check("gap_no_accept", 32'(acc_cnt), 32'(ac));
    check("gap_no_rsp", 32'(rsp_raw), 32'(rr));
    @(posedge clk); #1;
    set_table();
    t_vld = '1;
    tgt = acc_cnt + 1;
    wait_acc(tgt, 20);
    check("gap_ptr_hold", 32'(acc_q[$]), 32'(3));
    @(posedge clk); #1;
    t_vld = '0;
    wait_done(40);

    repeat (4) @(negedge clk);
    check("load_count", 32'(load_cnt), 32'(load_exp));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
